msix_wr_gen: RTL and testbench

- Synthesizable MSI-X interrupt message generator.
- Sits directly upstream of the host interface memory-write path: converts per-vector interrupt requests into single-DW posted writes (vector address, vector data) toward host memory, where the host side detects them as MSI-X events.
- Holds a per-vector table (address/data/valid), pending bits and round-robin arbitration; enforces a minimum gap between messages.

---
 rtl/msix_wr_gen_if.sv | 11 +
 rtl/msix_wr_gen.sv | 155 +++++++++++++++
 tb/tb_msix_wr_gen.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/msix_wr_gen_if.sv
// Single-DW posted-write request channel from the MSI-X generator toward the host
// memory-write path.
interface msix_wr_gen_if;
  logic        wr_valid;
  logic        wr_ready;
  logic [63:0] wr_addr;
  logic [31:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/msix_wr_gen.sv
// MSI-X message generator: per-vector table, pending bits, round-robin arbitration
// and a minimum idle gap between posted writes.
module msix_wr_gen #(
  parameter int NUM_VEC    = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_VEC-1:0]         intr_req,
  input  logic [NUM_VEC-1:0]         vec_mask,
  input  logic                       cfg_we,
  input  logic [$clog2(NUM_VEC)-1:0] cfg_idx,
  input  logic [63:0]                cfg_addr,
  input  logic [31:0]                cfg_data,
  input  logic                       cfg_valid,
  msix_wr_gen_if.master              wr,
  output logic [NUM_VEC-1:0]         pend,
  output logic                       sent,
  output logic [$clog2(NUM_VEC)-1:0] sent_id,
  output logic                       drop
);
  localparam int IW = $clog2(NUM_VEC);
  localparam logic [IW:0]   NV   = (IW+1)'(NUM_VEC);
  localparam logic [IW-1:0] LAST = IW'(NUM_VEC - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} state_t;

  state_t             state_reg;
  logic [63:0]        tbl_addr [NUM_VEC];
  logic [31:0]        tbl_data [NUM_VEC];
  logic [NUM_VEC-1:0] tbl_valid;
  logic [NUM_VEC-1:0] pend_reg, clr, elig, cfg_sel;
  logic [IW-1:0]      ptr_reg, grant_reg, sent_id_reg, win;
  logic [IW:0]        idx_sum;
  logic               any_elig, accept;
  logic               wr_valid_reg, sent_reg, drop_reg;
  logic [63:0]        wr_addr_reg;
  logic [31:0]        wr_data_reg;
  logic [3:0]         gap_cnt_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_VEC; gi++) begin : g_sel
      assign cfg_sel[gi] = cfg_we && (cfg_idx == IW'(gi));
    end
  endgenerate

  assign elig   = pend_reg & ~vec_mask;
  assign accept = (state_reg == ST_SEND) && wr.wr_ready;

  // Round-robin search: first eligible index at or after the pointer, wrapping.
  always_comb begin
    any_elig = 1'b0;
    win      = '0;
    idx_sum  = '0;
    for (int k = 0; k < NUM_VEC; k++) begin
      idx_sum = {1'b0, ptr_reg} + (IW+1)'(k);
      if (idx_sum >= NV) idx_sum = idx_sum - NV;
      if (!any_elig && elig[idx_sum[IW-1:0]]) begin
        any_elig = 1'b1;
        win      = idx_sum[IW-1:0];
      end
    end
  end

  always_comb begin
    clr = '0;
    if (state_reg == ST_IDLE && any_elig && !tbl_valid[win]) clr[win] = 1'b1;
    if (accept) clr[grant_reg] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl_valid <= '0;
      for (int i = 0; i < NUM_VEC; i++) begin
        tbl_addr[i] <= '0;
        tbl_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_VEC; i++) begin
        if (cfg_sel[i]) begin
          tbl_addr[i]  <= {cfg_addr[63:2], 2'b00};
          tbl_data[i]  <= cfg_data;
          tbl_valid[i] <= cfg_valid;
        end
      end
    end
  end

  // A request arriving in the same cycle as a clear re-arms the vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_reg <= '0;
    else        pend_reg <= (pend_reg & ~clr) | intr_req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      wr_valid_reg <= 1'b0;
      wr_addr_reg  <= '0;
      wr_data_reg  <= '0;
      sent_reg     <= 1'b0;
      sent_id_reg  <= '0;
      drop_reg     <= 1'b0;
      ptr_reg      <= '0;
      grant_reg    <= '0;
      gap_cnt_reg  <= '0;
    end else begin
      sent_reg <= 1'b0;
      drop_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (any_elig) begin
            if (tbl_valid[win]) begin
              wr_addr_reg  <= tbl_addr[win];
              wr_data_reg  <= tbl_data[win];
              wr_valid_reg <= 1'b1;
              grant_reg    <= win;
              state_reg    <= ST_SEND;
            end else begin
              drop_reg <= 1'b1;
            end
          end
        end
        ST_SEND: begin
          if (wr.wr_ready) begin
            wr_valid_reg <= 1'b0;
            sent_reg     <= 1'b1;
            sent_id_reg  <= grant_reg;
            ptr_reg      <= (grant_reg == LAST) ? '0 : grant_reg + 1'b1;
            if (GAP_CYCLES > 0) begin
              state_reg   <= ST_GAP;
              gap_cnt_reg <= 4'(GAP_CYCLES);
            end else begin
              state_reg <= ST_IDLE;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt_reg <= 4'd1) state_reg <= ST_IDLE;
          else                     gap_cnt_reg <= gap_cnt_reg - 4'd1;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign wr.wr_valid = wr_valid_reg;
  assign wr.wr_addr  = wr_addr_reg;
  assign wr.wr_data  = wr_data_reg;
  assign pend        = pend_reg;
  assign sent        = sent_reg;
  assign sent_id     = sent_id_reg;
  assign drop        = drop_reg;
endmodule

// File: tb/tb_msix_wr_gen.sv
// Directed self-checking bench for msix_wr_gen (NUM_VEC=8, GAP_CYCLES=2).
module tb_msix_wr_gen;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  intr_req, vec_mask;
  logic        cfg_we, cfg_valid;
  logic [2:0]  cfg_idx;
  logic [63:0] cfg_addr;
  logic [31:0] cfg_data;
  logic [7:0]  pend;
  logic        sent, drop;
  logic [2:0]  sent_id;
  int          checks = 0;
  int          errors = 0;

  msix_wr_gen_if bus();

  msix_wr_gen #(.NUM_VEC(8), .GAP_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .intr_req(intr_req), .vec_mask(vec_mask),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_valid(cfg_valid), .wr(bus), .pend(pend), .sent(sent), .sent_id(sent_id),
    .drop(drop)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; intr_req = '0; vec_mask = '0; cfg_we = 1'b0; cfg_idx = '0;
    cfg_addr = '0; cfg_data = '0; cfg_valid = 1'b0; bus.wr_ready = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic cfg_write(input logic [2:0] idx, input logic [63:0] a,
                           input logic [31:0] d, input logic v);
    cfg_we = 1'b1; cfg_idx = idx; cfg_addr = a; cfg_data = d; cfg_valid = v;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] v);
    intr_req = v;
    tick();
    intr_req = '0;
  endtask

  task automatic wait_sent(input int budget, output int n, output bit ok);
    n = 0; ok = 1'b0;
    while (n < budget && !ok) begin
      tick();
      n++;
      if (sent) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.wr_valid, bus.wr_addr, bus.wr_data, pend, sent, sent_id, drop} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b addr=%h data=%h pend=%b sent=%b id=%0d drop=%b expected all zero",
               bus.wr_valid, bus.wr_addr, bus.wr_data, pend, sent, sent_id, drop);
    end
  endtask

  task automatic test_single();
    do_reset();
    cfg_write(3'd3, 64'h0000_0001_0000_1000, 32'hDEAD0003, 1'b1);
    pulse(8'h08);
    checks++;
    if (pend !== 8'h08 || bus.wr_valid !== 1'b0) begin
      errors++; $display("FAIL single_pend: pend=%b valid=%b expected 00001000/0", pend, bus.wr_valid);
    end
    tick();
    checks++;
    if (bus.wr_valid !== 1'b1 || bus.wr_addr !== 64'h0000_0001_0000_1000 || bus.wr_data !== 32'hDEAD0003) begin
      errors++; $display("FAIL single_write: valid=%b addr=%h data=%h expected 1/0000000100001000/dead0003",
                         bus.wr_valid, bus.wr_addr, bus.wr_data);
    end
    tick();
    checks++;
    if (sent !== 1'b1 || sent_id !== 3'd3 || pend !== 8'h00 || bus.wr_valid !== 1'b0) begin
      errors++; $display("FAIL single_sent: sent=%b id=%0d pend=%b valid=%b expected 1/3/0/0",
                         sent, sent_id, pend, bus.wr_valid);
    end
    tick();
    checks++;
    if (sent !== 1'b0) begin
      errors++; $display("FAIL single_pulse_width: sent=%b expected 0", sent);
    end
  endtask

  task automatic test_round_robin();
    int n; bit ok;
    logic [2:0] order [5];
    int gaps [5];
    order = '{3'd1, 3'd5, 3'd6, 3'd1, 3'd6};
    gaps  = '{2, 4, 4, 2, 4};
    do_reset();
    for (int v = 0; v < 8; v++)
      cfg_write(3'(v), 64'h0000_0001_0000_1000 + 64'(v * 16), 32'hDEAD0000 | 32'(v),
                (v == 1 || v == 5 || v == 6));
    for (int k = 0; k < 5; k++) begin
      if (k == 0) pulse(8'b0110_0010);
      if (k == 3) begin
        repeat (6) tick();
        pulse(8'b0100_0010);
      end
      wait_sent(20, n, ok);
      checks++;
      if (!ok || n != gaps[k] || sent_id !== order[k]) begin
        errors++; $display("FAIL rr_order[%0d]: seen=%b cycles=%0d id=%0d expected 1/%0d/%0d",
                           k, ok, n, sent_id, gaps[k], order[k]);
      end
      checks++;
      if (bus.wr_data !== (32'hDEAD0000 | 32'(order[k]))) begin
        errors++; $display("FAIL rr_data[%0d]: data=%h expected %h", k, bus.wr_data,
                           32'hDEAD0000 | 32'(order[k]));
      end
    end
  endtask

  task automatic test_backpressure();
    int n_sent = 0;
    do_reset();
    cfg_write(3'd0, 64'h1234_5678_ABCD_0007, 32'hCAFE0000, 1'b1);
    bus.wr_ready = 1'b0;
    pulse(8'h01);
    tick();
    for (int c = 0; c < 5; c++) begin
      if (c == 2) cfg_write(3'd0, 64'h0, 32'h0BAD0BAD, 1'b1);
      else tick();
      checks++;
      if (bus.wr_valid !== 1'b1 || bus.wr_addr !== 64'h1234_5678_ABCD_0004 ||
          bus.wr_data !== 32'hCAFE0000 || sent !== 1'b0) begin
        errors++; $display("FAIL stall[%0d]: valid=%b addr=%h data=%h sent=%b expected 1/12345678abcd0004/cafe0000/0",
                           c, bus.wr_valid, bus.wr_addr, bus.wr_data, sent);
      end
    end
    bus.wr_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (sent) n_sent++;
    end
    checks++;
    if (n_sent != 1 || pend !== 8'h00) begin
      errors++; $display("FAIL stall_accept: sent_pulses=%0d pend=%b expected 1/0", n_sent, pend);
    end
  endtask

  task automatic test_mask_race();
    int n; bit ok; int n_valid = 0;
    do_reset();
    cfg_write(3'd2, 64'h0000_0000_0000_2000, 32'h0000_0002, 1'b1);
    vec_mask = 8'h04;
    pulse(8'h04);
    for (int c = 0; c < 6; c++) begin
      tick();
      if (bus.wr_valid) n_valid++;
    end
    checks++;
    if (pend !== 8'h04 || n_valid != 0) begin
      errors++; $display("FAIL masked: pend=%b valid_cycles=%0d expected 00000100/0", pend, n_valid);
    end
    vec_mask = 8'h00;
    tick();
    checks++;
    if (bus.wr_valid !== 1'b1) begin
      errors++; $display("FAIL unmask_issue: valid=%b expected 1", bus.wr_valid);
    end
    intr_req = 8'h04;
    tick();
    intr_req = '0;
    checks++;
    if (sent !== 1'b1 || pend !== 8'h04) begin
      errors++; $display("FAIL race_set_wins: sent=%b pend=%b expected 1/00000100", sent, pend);
    end
    wait_sent(20, n, ok);
    checks++;
    if (!ok || n != 4 || sent_id !== 3'd2) begin
      errors++; $display("FAIL race_rewrite: seen=%b cycles=%0d id=%0d expected 1/4/2", ok, n, sent_id);
    end
    n = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (sent) n++;
    end
    checks++;
    if (n != 0 || pend !== 8'h00) begin
      errors++; $display("FAIL race_no_extra: extra=%0d pend=%b expected 0/0", n, pend);
    end
  endtask

  task automatic test_invalid();
    int n_valid = 0;
    do_reset();
    cfg_write(3'd4, 64'h0000_0000_0000_4000, 32'h0000_0004, 1'b0);
    pulse(8'h10);
    checks++;
    if (pend !== 8'h10 || drop !== 1'b0) begin
      errors++; $display("FAIL invalid_pend: pend=%b drop=%b expected 00010000/0", pend, drop);
    end
    tick();
    checks++;
    if (drop !== 1'b1 || pend !== 8'h00 || bus.wr_valid !== 1'b0) begin
      errors++; $display("FAIL invalid_drop: drop=%b pend=%b valid=%b expected 1/0/0", drop, pend, bus.wr_valid);
    end
    tick();
    checks++;
    if (drop !== 1'b0) begin
      errors++; $display("FAIL drop_width: drop=%b expected 0", drop);
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      if (bus.wr_valid) n_valid++;
    end
    checks++;
    if (n_valid != 0) begin
      errors++; $display("FAIL invalid_no_write: valid_cycles=%0d expected 0", n_valid);
    end
  endtask

  task automatic test_reset_mid_send();
    int n_valid = 0; int n_drop = 0;
    do_reset();
    cfg_write(3'd3, 64'h0000_0001_0000_1000, 32'hDEAD0003, 1'b1);
    bus.wr_ready = 1'b0;
    pulse(8'h08);
    tick();
    checks++;
    if (bus.wr_valid !== 1'b1) begin
      errors++; $display("FAIL pre_reset_valid: valid=%b expected 1", bus.wr_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.wr_valid, bus.wr_addr, bus.wr_data, pend, sent, sent_id, drop} !== '0) begin
      errors++; $display("FAIL async_reset: valid=%b addr=%h data=%h pend=%b sent=%b drop=%b expected all zero",
                         bus.wr_valid, bus.wr_addr, bus.wr_data, pend, sent, drop);
    end
    tick();
    rst_n = 1'b1;
    bus.wr_ready = 1'b1;
    pulse(8'h08);
    for (int c = 0; c < 8; c++) begin
      tick();
      if (bus.wr_valid) n_valid++;
      if (drop) n_drop++;
    end
    checks++;
    if (n_valid != 0 || n_drop != 1) begin
      errors++; $display("FAIL table_cleared: valid_cycles=%0d drops=%0d expected 0/1", n_valid, n_drop);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_mask_race();
    test_invalid();
    test_reset_mid_send();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
